blocking: RTL and testbench
===========================

// Module: blocking
//
// PURPOSE
//   Two-register swap cell for demonstrating register update ordering.
//   Reset loads registers A and B from the a_i/b_i inputs.
//   After reset is released, A and B exchange contents on every clock edge.
//   An optional mode makes both registers take B's old value instead; this
//   mirrors sequential blocking-update ordering.
//   Stand-alone leaf block with no handshake; it drives its outputs straight
//   from the two registers.
//
// PARAMETERS
//   WIDTH  1  bit width of a_i, b_i, a_o, b_o (legal range >= 1)
//   MODE   0  0 = true swap (A<-old B, B<-old A); 1 = ordered update (A<-old B, B<-new A = old B)
//
// PORTS
//   clk    input   1      rising-edge clock; the only clock
//   rst_n  input   1      synchronous, active-HIGH reset (the name is kept for codebase
//                         consistency; rst_n==1 at a rising clk edge = reset)
//   a_i    input   WIDTH  load value for register A, sampled only during reset
//   b_i    input   WIDTH  load value for register B, sampled only during reset
//   a_o    output  WIDTH  register A, driven directly from its flop
//   b_o    output  WIDTH  register B, driven directly from its flop
//
// BEHAVIOUR
//   - All state changes occur on the rising edge of clk. There is no asynchronous path.
//   - Reset (rst_n==1 at posedge): a_o <= a_i and b_o <= b_i.
//     The reset values of the outputs are therefore the input values, not constants.
//     Reset takes priority over everything else.
//     Held reset reloads a_i/b_i on every edge, so outputs track the inputs with 1-cycle latency.
//   - Run (rst_n==0 at posedge), MODE==0: a_o <= b_o and b_o <= a_o.
//     Both use pre-edge values, so the contents swap each cycle with period 2.
//   - Run, MODE==1: a_o <= b_o and b_o <= b_o. Both registers end up holding old B.
//     The state is then stable (a_o==b_o) from the first run edge onward.
//   - a_i and b_i are ignored while not in reset. Changing them mid-run has no effect.
//   - Reset asserted mid-operation reloads from a_i/b_i on that edge, regardless of swap phase.
//   - Equal contents (a_o==b_o) are stable in both modes.
//   - Before the first reset edge, the outputs are undefined. Users must apply at least
//     one reset cycle.
//   - No arithmetic is performed; WIDTH bits move unchanged, and there is no truncation or extension.
//   - Outputs are glitch-free register outputs. There is no combinational path from
//     inputs to outputs.
//
// TESTING
//   1. MODE=0, WIDTH=1: reset with a_i=1, b_i=0 -> a_o=1, b_o=0.
//      Release -> edge 1: a_o=0, b_o=1; edge 2: a_o=1, b_o=0; alternation continues.
//   2. MODE=1, WIDTH=1: reset with a_i=1, b_i=0, then release -> edge 1: a_o=0, b_o=0;
//      the outputs stay 0/0 on all later edges.
//   3. Reset mid-run: MODE=0 swapping, assert reset with a_i=0, b_i=1 at an arbitrary phase
//      -> next edge a_o=0, b_o=1; after release the swap resumes from that state.
//   4. Input isolation: in run mode, toggle a_i/b_i every cycle -> a_o/b_o follow only the
//      swap pattern and never reflect a_i/b_i.
//   5. WIDTH=8, MODE=0: reset with a_i=8'hA5, b_i=8'h3C -> A5/3C.
//      Run -> 3C/A5, then A5/3C; all bits intact.
//   6. Held reset: keep rst_n=1 and change a_i/b_i every cycle -> a_o/b_o equal the
//      previous cycle's a_i/b_i.

Source files
------------

// File: rtl/blocking.sv
// Two-register swap cell: reset loads A/B from the inputs, run mode either swaps
// the registers (MODE 0) or copies old B into both (MODE 1).
module blocking #(
  parameter int WIDTH = 1,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  // rst_n is active-high despite its name; reload wins over any swap phase
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_o <= a_i;
      b_o <= b_i;
    end else begin
      a_o <= b_o;
      b_o <= (MODE != 0) ? b_o : a_o;
    end
  end

endmodule

// File: tb/tb_blocking.sv
// Directed bench for blocking: three instances (swap 1-bit, ordered 1-bit, swap 8-bit)
// share clock and reset; each task drives vectors and checks hand-computed values.
module tb_blocking;

  logic       clk;
  logic       rst_n;
  logic       a1, b1;
  logic [7:0] a8, b8;
  logic       m0_a, m0_b, m1_a, m1_b;
  logic [7:0] w8_a, w8_b;

  int vectors;
  int fails;

  logic       e0a, e0b, e1a, e1b;
  logic [7:0] e8a, e8b;

  blocking #(.WIDTH(1), .MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .a_i(a1), .b_i(b1), .a_o(m0_a), .b_o(m0_b));
  blocking #(.WIDTH(1), .MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .a_i(a1), .b_i(b1), .a_o(m1_a), .b_o(m1_b));
  blocking #(.WIDTH(8), .MODE(0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a_i(a8), .b_i(b8), .a_o(w8_a), .b_o(w8_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int cyc);
    vectors++;
    if (m0_a !== e0a || m0_b !== e0b) begin
      fails++;
      $display("[TB] FAIL %s mode0 cyc %0d: a_o/b_o=%b/%b expected %b/%b",
               tag, cyc, m0_a, m0_b, e0a, e0b);
    end
    vectors++;
    if (m1_a !== e1a || m1_b !== e1b) begin
      fails++;
      $display("[TB] FAIL %s mode1 cyc %0d: a_o/b_o=%b/%b expected %b/%b",
               tag, cyc, m1_a, m1_b, e1a, e1b);
    end
    vectors++;
    if (w8_a !== e8a || w8_b !== e8b) begin
      fails++;
      $display("[TB] FAIL %s width8 cyc %0d: a_o/b_o=%h/%h expected %h/%h",
               tag, cyc, w8_a, w8_b, e8a, e8b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; a1 = 1'b1; b1 = 1'b0; a8 = 8'hA5; b8 = 8'h3C;
    step();
    e0a = 1'b1; e0b = 1'b0; e1a = 1'b1; e1b = 1'b0; e8a = 8'hA5; e8b = 8'h3C;
    check_all("reset", 0);
  endtask

  task automatic test_swap();
    logic [1:0] exp0 [0:5];
    logic [15:0] exp8 [0:5];
    exp0 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    exp8 = '{16'h3CA5, 16'hA53C, 16'h3CA5, 16'hA53C, 16'h3CA5, 16'hA53C};
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      {e0a, e0b} = exp0[i];
      e1a = 1'b0; e1b = 1'b0;
      {e8a, e8b} = exp8[i];
      check_all("swap", i + 1);
    end
  endtask

  task automatic test_input_isolation();
    // drive inputs to the opposite of what the registers should hold next
    for (int i = 0; i < 6; i++) begin
      a1 = ~e0b; b1 = ~e0a; a8 = ~e8b; b8 = ~e8a;
      step();
      {e0a, e0b} = {e0b, e0a};
      {e8a, e8b} = {e8b, e8a};
      check_all("isolation", i);
    end
  endtask

  task automatic test_mid_reset();
    step();
    rst_n = 1'b1; a1 = 1'b0; b1 = 1'b1; a8 = 8'h81; b8 = 8'h7E;
    step();
    e0a = 1'b0; e0b = 1'b1; e1a = 1'b0; e1b = 1'b1; e8a = 8'h81; e8b = 8'h7E;
    check_all("midreset", 0);
    rst_n = 1'b0; a1 = 1'b1; b1 = 1'b0; a8 = 8'h00; b8 = 8'hFF;
    step();
    e0a = 1'b1; e0b = 1'b0; e1a = 1'b1; e1b = 1'b1; e8a = 8'h7E; e8b = 8'h81;
    check_all("midreset", 1);
    step();
    e0a = 1'b0; e0b = 1'b1; e8a = 8'h81; e8b = 8'h7E;
    check_all("midreset", 2);
  endtask

  task automatic test_held_reset();
    logic [1:0]  in1 [0:4];
    logic [15:0] in8 [0:4];
    in1 = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
    in8 = '{16'h1234, 16'hFF00, 16'h00FF, 16'hC35A, 16'h0102};
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {a1, b1} = in1[i];
      {a8, b8} = in8[i];
      step();
      {e0a, e0b} = in1[i];
      {e1a, e1b} = in1[i];
      {e8a, e8b} = in8[i];
      check_all("heldreset", i);
    end
  endtask

  task automatic test_equal_stable();
    rst_n = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'h77; b8 = 8'h77;
    step();
    rst_n = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    e0a = 1'b1; e0b = 1'b1; e1a = 1'b1; e1b = 1'b1; e8a = 8'h77; e8b = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("equal", i);
    end
  endtask

  initial begin
    vectors = 0;
    fails   = 0;
    rst_n = 1'b1; a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_swap();
    test_input_isolation();
    test_mid_reset();
    test_held_reset();
    test_equal_stable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
